// File: rtl/adder_seq.sv
// adder_seq: multi-cycle adder. It adds CHUNK bits per clock, least
// significant chunk first, and carries between chunks in a register.
// Operands and carry-in are captured on the accept edge. The result is
// published on the BUSY->DONE edge together with a one-cycle done_o pulse.
// Optional feature: define ADDER_SEQ_OVF_EN to add the signed-overflow
// output ovf_o.
module adder_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] r1_i,
    input  logic [WIDTH-1:0] r2_i,
    input  logic             ci_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             done_o
`ifdef ADDER_SEQ_OVF_EN
    ,
    output logic             ovf_o
`endif
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic [CHUNK:0]   csum;
    int               base;
`ifdef ADDER_SEQ_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Next-state logic: the accept edge captures operands, each BUSY cycle
    // adds one chunk, and the final chunk publishes the result.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        cy_d     = cy_q;
        carry_d  = carry_q;
`ifdef ADDER_SEQ_OVF_EN
        ovf_d    = ovf_q;
`endif
        base = 32'(cnt_q) * CHUNK;
        csum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
             + (CHUNK+1)'(cy_q);
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = BUSY;
                    a_d     = r1_i;
                    b_d     = r2_i;
                    cy_d    = ci_i;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            BUSY: begin
                cy_d                = csum[CHUNK];
                acc_d[base +: CHUNK] = csum[CHUNK-1:0];
                if (cnt_q == CW'(N-1)) begin
                    // Last chunk: the counter stops here and does not wrap.
                    state_d  = DONE;
                    result_d = acc_d;
                    carry_d  = csum[CHUNK];
`ifdef ADDER_SEQ_OVF_EN
                    ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                               (acc_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        done_d  = (state_d == DONE);
        ready_d = (state_d == IDLE);
    end

    // State and registered outputs. Reset clears everything and aborts any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            cy_q     <= 1'b0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
`ifdef ADDER_SEQ_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            cy_q     <= cy_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
`ifdef ADDER_SEQ_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign ready_o  = ready_q;
    assign result_o = result_q;
    assign carry_o  = carry_q;
    assign done_o   = done_q;
`ifdef ADDER_SEQ_OVF_EN
    assign ovf_o    = ovf_q;
`endif

endmodule

// File: doc/adder_seq.md
ADDER_SEQ -- requirements
Module: adder_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 clk_i  input  1  sole clock, rising-edge active.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 start_i  input  1  request to add; accepted only when ready_o=1.
REQ-006 r1_i  input  WIDTH  operand A, sampled on accept edge only.
REQ-007 r2_i  input  WIDTH  operand B, sampled on accept edge only.
REQ-008 ci_i  input  1  carry-in, sampled on accept edge only.
REQ-009 ready_o  output  1  high only in IDLE.
REQ-010 result_o  output  WIDTH  registered sum of last completed operation.
REQ-011 carry_o  output  1  registered carry-out of last completed operation.
REQ-012 done_o  output  1  one-cycle completion pulse.

Function
REQ-013 FSM states IDLE, BUSY, DONE; IDLE->BUSY on start_i&ready_o; BUSY->DONE after N BUSY cycles; DONE->IDLE unconditionally next edge.
REQ-014 Accept edge latches r1_i, r2_i, ci_i into internal registers; input changes afterwards SHALL not affect the operation.
REQ-015 BUSY cycle k (0..N-1) adds bits [k*CHUNK +: CHUNK] of both operands plus running carry; running carry starts at latched ci_i.
REQ-016 Full sum is arithmetic (A + B + ci) mod 2^WIDTH; carry_o = bit WIDTH of the exact sum.
REQ-017 result_o and carry_o update only on the BUSY->DONE edge, held stable otherwise, including during subsequent BUSY.
REQ-018 done_o =1 exactly in DONE state, i.e. asserted after N rising edges following the accept edge, for one cycle.
REQ-019 start_i in BUSY or DONE SHALL be ignored (no queueing); back-to-back throughput is one op per N+2 cycles.
REQ-020 CHUNK = WIDTH SHALL work: one BUSY cycle, done_o after 1 edge.
REQ-021 Chunk counter SHALL not wrap mid-operation; it is cleared on accept.

Reset
REQ-022 rst_i high forces immediately: state IDLE, ready_o=1, done_o=0, result_o=0, carry_o=0, internal operands/counter/carry=0.
REQ-023 Reset during BUSY or DONE aborts the operation; no done_o pulse; outputs read zero.
REQ-024 First accept possible on first rising edge after rst_i deasserts.

Configuration
REQ-025 Macro ADDER_SEQ_OVF_EN: when defined, add output ovf_o (output, 1) = two's-complement signed overflow of the completed op (A[MSB]==B[MSB] and result_o[MSB]!=A[MSB]), registered with result_o, reset 0.
REQ-026 Without ADDER_SEQ_OVF_EN, port ovf_o and its logic SHALL not exist; all other behaviour identical.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-027 Accept r1=0x000A, r2=0x0002, ci=1 -> done_o high 4 edges later, result_o=0x000D, carry_o=0.
REQ-028 r1=0xFFFF, r2=0xFFFF, ci=0 -> result_o=0xFFFE, carry_o=1; r1=0x0FFF, r2=0x0001, ci=0 -> 0x1000, carry_o=0 (cross-chunk propagation).
REQ-029 start_i held high with new operands throughout BUSY -> single done_o pulse, result from first operands only; ready_o low in BUSY/DONE.
REQ-030 Assert rst_i at BUSY cycle 2 -> ready_o=1, result_o=0, no done_o; next op 0x0005+0x000A -> 0x000F.
REQ-031 With ADDER_SEQ_OVF_EN: 0x7FFF+0x0001 -> ovf_o=1, carry_o=0; 0xFFFF+0x0001 -> ovf_o=0, carry_o=1.
REQ-032 WIDTH=4, CHUNK=4: 1010+0010+ci 1 -> result_o=1101, carry_o=0, done_o after 1 edge; 1111+1111 -> 1110, carry_o=1.
